// File: rtl/arm_fetch.sv
// Instruction fetch stage: one outstanding word read, PC-tagged prefetch FIFO, branch redirect with drain.
// Optional ARM_FETCH_ALIGN_CHECK_EN adds a one-cycle align_fault pulse for misaligned branch targets.
module arm_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  input  logic                     branch_valid,
  input  logic [31:0]              branch_target,
  input  logic                     stall,
  output logic                     instr_valid,
  output logic [31:0]              instruction,
  output logic [31:0]              instr_pc,
  output logic [$clog2(DEPTH):0]   buf_count
`ifdef ARM_FETCH_ALIGN_CHECK_EN
  ,
  output logic                     align_fault
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  logic [0:0]    state;
  logic [31:0]   fetch_pc;
  logic [31:0]   fifo_dat [DEPTH];
  logic [31:0]   fifo_pc  [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          ack;
  logic          push;
  logic          pop;
  logic          issue;
  logic [31:0]   branch_pc;

  assign ack       = mem_req && mem_ack;
  assign push      = ack && (state == S_FETCH) && !branch_valid;
  assign pop       = instr_valid && !stall && !branch_valid;
  assign branch_pc = branch_target & 32'hFFFF_FFFC;
  // Outstanding request is mem_req itself, so "count < DEPTH" with !mem_req covers count+outstanding.
  assign issue     = (state == S_FETCH) && !mem_req && !branch_valid && (count < DEPTH_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      fetch_pc <= RESET_PC & 32'hFFFF_FFFC;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (issue) begin
        mem_req  <= 1'b1;
        mem_addr <= fetch_pc;
      end else if (ack) begin
        mem_req  <= 1'b0;
      end

      case (state)
        S_FETCH: if (branch_valid && mem_req && !mem_ack) state <= S_DRAIN;
        S_DRAIN: if (mem_ack) state <= S_FETCH;
        default: state <= S_FETCH;
      endcase

      if (branch_valid)
        fetch_pc <= branch_pc;
      else if (push)
        fetch_pc <= fetch_pc + 32'd4;

      if (branch_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dat[wr_ptr] <= mem_rdata;
      fifo_pc[wr_ptr]  <= mem_addr;
    end
  end

`ifdef ARM_FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) align_fault <= 1'b0;
    else     align_fault <= branch_valid && (branch_target[1:0] != 2'b00);
  end
`endif

  assign instr_valid = (count != '0);
  assign instruction = instr_valid ? fifo_dat[rd_ptr] : 32'h0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]  : 32'h0;
  assign buf_count   = count;

endmodule

// File: tb/tb_arm_fetch.sv
// Bench for arm_fetch: cycle-stepped memory/decode model with a scoreboard queue of expected FIFO entries.
module tb_arm_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic [1:0]  buf_count;
`ifdef ARM_FETCH_ALIGN_CHECK_EN
  logic        align_fault;
  logic        align_fault2;
`endif

  logic        rst2;
  logic        mem_req2;
  logic [31:0] mem_addr2;
  logic        mem_ack2;
  logic [31:0] mem_rdata2;
  logic        branch_valid2;
  logic [31:0] branch_target2;
  logic        stall2;
  logic        instr_valid2;
  logic [31:0] instruction2;
  logic [31:0] instr_pc2;
  logic [1:0]  buf_count2;

  arm_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .branch_valid(branch_valid), .branch_target(branch_target), .stall(stall),
    .instr_valid(instr_valid), .instruction(instruction), .instr_pc(instr_pc),
    .buf_count(buf_count)
`ifdef ARM_FETCH_ALIGN_CHECK_EN
    , .align_fault(align_fault)
`endif
  );

  arm_fetch #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst2),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack2), .mem_rdata(mem_rdata2),
    .branch_valid(branch_valid2), .branch_target(branch_target2), .stall(stall2),
    .instr_valid(instr_valid2), .instruction(instruction2), .instr_pc(instr_pc2),
    .buf_count(buf_count2)
`ifdef ARM_FETCH_ALIGN_CHECK_EN
    , .align_fault(align_fault2)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] dat;
  } entry_t;

  entry_t      q[$];
  int          checks = 0;
  int          errors = 0;
  int          ack_delay;
  int          wait_cnt;
  int          req_len;
  int          last_req_len;
  int          issues;
  bit          drain;
  bit          prev_held;
  bit          spurious;
  logic [31:0] prev_addr;
  logic [31:0] exp_pc;
  logic [31:0] cur_addr;
  logic [31:0] last_issue_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hA5C3_0000) + 32'h0000_1111;
  endfunction

  // One clock: answer memory, update the model, drive inputs, then compare at the next negedge.
  task automatic tick(input bit br, input logic [31:0] tgt, input bit stl);
    bit     ack;
    bit     was_req;
    entry_t e;
    was_req = mem_req;
    ack = 1'b0;
    if (mem_req) begin
      req_len++;
      if (wait_cnt >= ack_delay) begin
        ack = 1'b1;
        wait_cnt = 0;
        last_req_len = req_len;
        req_len = 0;
      end else begin
        wait_cnt++;
      end
    end
    if (br) begin
      q.delete();
    end else begin
      if (q.size() > 0 && !stl) void'(q.pop_front());
      if (ack && !drain) begin
        e.pc  = cur_addr;
        e.dat = mem_word(cur_addr);
        q.push_back(e);
      end
    end
    if (br)                 exp_pc = tgt & 32'hFFFF_FFFC;
    else if (ack && !drain) exp_pc = exp_pc + 32'd4;
    if (ack)                drain = 1'b0;
    else if (br && mem_req) drain = 1'b1;
    prev_held = mem_req && !ack;
    prev_addr = mem_addr;

    mem_ack       = ack | (spurious & !mem_req);
    mem_rdata     = ack ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    stall         = stl;
    branch_valid  = br;
    branch_target = tgt;
    @(negedge clk);

    checks++;
    if (instr_valid !== (q.size() != 0)) begin
      errors++; $display("FAIL instr_valid: got %b want %b", instr_valid, q.size() != 0);
    end
    checks++;
    if (int'(buf_count) != q.size()) begin
      errors++; $display("FAIL buf_count: got %0d want %0d", buf_count, q.size());
    end
    checks++;
    if (q.size() != 0) begin
      if (instruction !== q[0].dat || instr_pc !== q[0].pc) begin
        errors++; $display("FAIL head: got %h@%h want %h@%h", instruction, instr_pc, q[0].dat, q[0].pc);
      end
    end else if (instruction !== 32'h0 || instr_pc !== 32'h0) begin
      errors++; $display("FAIL empty_head: got %h@%h want 0@0", instruction, instr_pc);
    end
    if (prev_held) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin
        errors++; $display("FAIL req_hold: got req %b addr %h want 1 addr %h", mem_req, mem_addr, prev_addr);
      end
    end
    if (was_req && ack) begin
      checks++;
      if (mem_req !== 1'b0) begin
        errors++; $display("FAIL req_drop: got %b want 0", mem_req);
      end
    end
    if (mem_req && !was_req) begin
      checks++;
      if (mem_addr !== exp_pc) begin
        errors++; $display("FAIL issue_addr: got %h want %h", mem_addr, exp_pc);
      end
      issues++;
      last_issue_addr = mem_addr;
      cur_addr = exp_pc;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    branch_valid = 1'b0;
    branch_target = 32'h0;
    stall = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0 || instruction !== 32'h0 ||
        instr_pc !== 32'h0 || buf_count !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: got req %b vld %b ins %h pc %h cnt %0d want all 0",
               mem_req, instr_valid, instruction, instr_pc, buf_count);
    end
`ifdef ARM_FETCH_ALIGN_CHECK_EN
    checks++;
    if (align_fault !== 1'b0) begin
      errors++; $display("FAIL reset_align_fault: got %b want 0", align_fault);
    end
`endif
    rst = 1'b0;
    mem_ack = 1'b0;
    q.delete();
    drain = 1'b0; prev_held = 1'b0; spurious = 1'b0;
    exp_pc = 32'h0; cur_addr = 32'h0;
    wait_cnt = 0; req_len = 0; last_req_len = 0; ack_delay = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tick(1'b0, 32'h0, 1'b0);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL first_req: got req %b addr %h want 1 addr 0", mem_req, mem_addr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    do_reset();
    for (int t = 1; t <= 8; t++) begin
      tick(1'b0, 32'h0, 1'b0);
      checks++;
      if (t % 2 == 0) begin
        pc = 32'((t / 2 - 1) * 4);
        if (instr_valid !== 1'b1 || instr_pc !== pc || instruction !== mem_word(pc)) begin
          errors++;
          $display("FAIL stream_word: cycle %0d got vld %b %h@%h want 1 %h@%h",
                   t, instr_valid, instruction, instr_pc, mem_word(pc), pc);
        end
      end else if (instr_valid !== 1'b0) begin
        errors++; $display("FAIL stream_gap: cycle %0d got vld %b want 0", t, instr_valid);
      end
    end
  endtask

  task automatic test_stall();
    int n;
    do_reset();
    spurious = 1'b1;
    repeat (10) tick(1'b0, 32'h0, 1'b1);
    checks++;
    if (buf_count !== 2'd2 || mem_req !== 1'b0) begin
      errors++; $display("FAIL stall_full: got cnt %0d req %b want 2 0", buf_count, mem_req);
    end
    n = issues;
    tick(1'b0, 32'h0, 1'b0);
    checks++;
    if (buf_count !== 2'd1) begin
      errors++; $display("FAIL stall_pop: got cnt %0d want 1", buf_count);
    end
    repeat (8) tick(1'b0, 32'h0, 1'b1);
    checks++;
    if (issues - n != 1 || buf_count !== 2'd2) begin
      errors++; $display("FAIL stall_refill: got %0d issues cnt %0d want 1 issue cnt 2", issues - n, buf_count);
    end
    spurious = 1'b0;
    repeat (4) tick(1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_delayed_ack();
    do_reset();
    ack_delay = 3;
    for (int i = 0; i < 12 && last_req_len == 0; i++) tick(1'b0, 32'h0, 1'b0);
    checks++;
    if (last_req_len != 4) begin
      errors++; $display("FAIL delay_req_len: got %0d want 4", last_req_len);
    end
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instruction !== mem_word(32'h0)) begin
      errors++; $display("FAIL delay_data: got vld %b %h@%h want 1 %h@0", instr_valid, instruction, instr_pc, mem_word(32'h0));
    end
  endtask

  task automatic test_branch_drain();
    bit          found;
    int          n;
    logic [31:0] first_pc;
    logic [31:0] first_issue;
    do_reset();
    ack_delay = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mem_req && mem_addr == 32'h8) found = 1'b1;
      else tick(1'b0, 32'h0, 1'b0);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL drain_setup: got no request to 8 want one");
    end
    n = issues;
    tick(1'b1, 32'h100, 1'b0);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h8 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL drain_hold: got req %b addr %h vld %b want 1 8 0", mem_req, mem_addr, instr_valid);
    end
    first_pc = 32'hFFFF_FFFF;
    first_issue = 32'hFFFF_FFFF;
    for (int i = 0; i < 40 && first_pc == 32'hFFFF_FFFF; i++) begin
      tick(1'b0, 32'h0, 1'b0);
      if (issues != n && first_issue == 32'hFFFF_FFFF) first_issue = last_issue_addr;
      if (instr_valid) first_pc = instr_pc;
    end
    checks++;
    if (first_issue !== 32'h100 || first_pc !== 32'h100) begin
      errors++; $display("FAIL drain_redirect: got issue %h pc %h want 100 100", first_issue, first_pc);
    end
  endtask

  task automatic test_branch_ack_pop();
    bit found;
    int n;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (buf_count == 2'd1 && mem_req) found = 1'b1;
      else tick(1'b0, 32'h0, 1'b1);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL bap_setup: got no cnt1+req cycle want one");
    end
    tick(1'b1, 32'h200, 1'b0);
    checks++;
    if (buf_count !== 2'd0 || instr_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL bap_flush: got cnt %0d vld %b req %b want 0 0 0", buf_count, instr_valid, mem_req);
    end
    n = issues;
    for (int i = 0; i < 10 && issues == n; i++) tick(1'b0, 32'h0, 1'b0);
    checks++;
    if (issues == n || last_issue_addr !== 32'h200) begin
      errors++; $display("FAIL bap_resume: got addr %h want 200", last_issue_addr);
    end
  endtask

  task automatic test_align();
    do_reset();
    tick(1'b1, 32'h102, 1'b0);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL align_noreq: got %b want 0", mem_req);
    end
`ifdef ARM_FETCH_ALIGN_CHECK_EN
    checks++;
    if (align_fault !== 1'b1) begin
      errors++; $display("FAIL align_pulse: got %b want 1", align_fault);
    end
`endif
    tick(1'b0, 32'h0, 1'b0);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      errors++; $display("FAIL align_target: got req %b addr %h want 1 100", mem_req, mem_addr);
    end
`ifdef ARM_FETCH_ALIGN_CHECK_EN
    checks++;
    if (align_fault !== 1'b0) begin
      errors++; $display("FAIL align_clear: got %b want 0", align_fault);
    end
`endif
    repeat (4) tick(1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_wrap();
    logic [31:0] addrs[$];
    logic [31:0] pcs[$];
    @(negedge clk);
    rst2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mem_ack2   = mem_req2;
      mem_rdata2 = mem_word(mem_addr2);
      if (mem_req2) addrs.push_back(mem_addr2);
      if (instr_valid2) pcs.push_back(instr_pc2);
      @(negedge clk);
    end
    checks++;
    if (addrs.size() < 2 || addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr: got %0d reqs first %h second %h want FFFFFFFC 0",
               addrs.size(), addrs.size() > 0 ? addrs[0] : 32'hX, addrs.size() > 1 ? addrs[1] : 32'hX);
    end
    checks++;
    if (pcs.size() < 2 || pcs[0] !== 32'hFFFF_FFFC || pcs[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pc: got %0d words first %h second %h want FFFFFFFC 0",
               pcs.size(), pcs.size() > 0 ? pcs[0] : 32'hX, pcs.size() > 1 ? pcs[1] : 32'hX);
    end
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
    branch_valid = 1'b0; branch_target = 32'h0; stall = 1'b0;
    rst2 = 1'b1; mem_ack2 = 1'b0; mem_rdata2 = 32'h0;
    branch_valid2 = 1'b0; branch_target2 = 32'h0; stall2 = 1'b0;
    issues = 0; last_issue_addr = 32'h0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_delayed_ack();
    test_branch_drain();
    test_branch_ack_pop();
    test_align();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/arm_fetch.md
Name: arm_fetch

Overview:
- Instruction fetch stage sitting directly upstream of the instruction decoder.
- Holds the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words, tagged with their PC, in a small prefetch FIFO; presents the FIFO head to decode with a valid/stall handshake.
- Accepts branch redirects that flush the buffer and restart fetch at a new target.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- DEPTH, 2, prefetch FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_req  output  1  read request to instruction memory.
- mem_addr  output  32  word address of the current request; bits [1:0] always 0.
- mem_ack  input  1  memory has returned mem_rdata for the current request this cycle.
- mem_rdata  input  32  instruction word; valid only when mem_ack=1.
- branch_valid  input  1  redirect request, single-cycle pulse.
- branch_target  input  32  new fetch address; sampled when branch_valid=1.
- stall  input  1  decode cannot accept the head this cycle.
- instr_valid  output  1  FIFO head is valid.
- instruction  output  32  FIFO head word; 0 when instr_valid=0.
- instr_pc  output  32  address of the head word; 0 when instr_valid=0.
- buf_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at edge) sets fetch_pc=RESET_PC, empties the FIFO and clears the outstanding flag. State becomes FETCH.
  - Outputs during and after reset until the first push: mem_req=0, instr_valid=0, instruction=0, instr_pc=0, buf_count=0.
  - Reset mid-transaction abandons the request; a pending ack is ignored.
- At most one outstanding request.
  - Request condition: state FETCH and no request outstanding and (buf_count + outstanding) < DEPTH.
  - The request is registered, so mem_req rises the cycle after the condition holds. The first mem_req therefore appears one cycle after rst deasserts.
- While mem_req=1, mem_req and mem_addr stay stable until the cycle mem_ack=1. mem_req is never withdrawn early.
- A zero-wait ack (asserted in the first mem_req cycle) is legal.
- On ack in state FETCH:
  - push {mem_rdata, mem_addr} into the FIFO;
  - fetch_pc <= fetch_pc + 4, with 32-bit wrap (32'hFFFF_FFFC -> 0);
  - mem_req drops for at least one cycle.
  - Back-to-back throughput is one word every 2 cycles with zero-wait memory.
- Pushed data is visible on instruction/instr_pc with instr_valid=1 the cycle after the ack.
- Pop happens when instr_valid=1 and stall=0.
  - A simultaneous push and pop keeps buf_count unchanged.
  - No push is ever attempted on a full FIFO, because occupancy accounting includes the outstanding request.
- Branch (branch_valid=1) has priority over push and pop in the same cycle:
  - FIFO cleared (next cycle instr_valid=0, buf_count=0); the same-cycle pop does not matter.
  - fetch_pc <= {branch_target[31:2], 2'b00}.
  - No request outstanding: stay FETCH; the next request goes to the target.
  - Request outstanding, not acked this cycle: go to DRAIN. mem_req stays high at the old address until ack; the returned data is discarded; then go to FETCH.
  - Request acked in the same cycle as the branch: data discarded, stay FETCH.
  - Branch while in DRAIN: fetch_pc updated to the newer target, stay DRAIN.
- States:
  - FETCH --branch with request outstanding and no ack--> DRAIN.
  - DRAIN --ack--> FETCH.
- mem_ack while mem_req=0 is ignored.

Optional Feature:
- Macro: ARM_FETCH_ALIGN_CHECK_EN.
- Defined:
  - adds output port align_fault (1 bit), reset 0;
  - align_fault pulses high for exactly one cycle, the cycle after branch_valid=1 with branch_target[1:0] != 0;
  - the redirect still proceeds to the word-aligned address.
- Undefined: the port is absent; low target bits are silently truncated.

Test Plan:
- Reset then zero-wait memory, stall=0: mem_req rises 1 cycle after rst deasserts; words W0..W3 appear with instr_pc 0,4,8,C; one word every 2 cycles.
- stall=1 held, DEPTH=2: buf_count reaches 2 and mem_req stays 0; release stall for one cycle -> buf_count 1 and exactly one new request issues.
- Memory ack delayed 3 cycles: mem_addr is stable and mem_req is high for all 4 cycles; ack -> instruction=mem_rdata next cycle.
- Branch to 32'h100 while a request to 32'h8 waits: state DRAIN; the ack for 8 is dropped; next mem_addr=32'h100; instr_pc of the first valid word = 32'h100.
- Branch in the same cycle as ack and pop with FIFO at 1: next cycle buf_count=0 and instr_valid=0; fetch resumes at the target.
- RESET_PC=32'hFFFF_FFFC: the second fetch address wraps to 0. With ARM_FETCH_ALIGN_CHECK_EN, a branch to 32'h102 -> one-cycle align_fault and fetch at 32'h100.
